// File: rtl/hier_pkg.sv
// ---------------------------------------------------------------------------
// hier_pkg
// Shared types for the depth-first hierarchy token stream decoder.
//   - hier_state_e : decoder FSM states (START expects a root, RUN decodes,
//                    DRAIN discards a malformed tree up to its last token)
//   - token_t      : one (depth, id, last) token at the default widths
//   - edge_t       : one reconstructed parent->child edge at default widths
//   - sat_inc16    : saturating 16-bit increment used by the statistics
// No ports (package).
// ---------------------------------------------------------------------------
package hier_pkg;

    localparam int HIER_ID_W      = 8;
    localparam int HIER_MAX_DEPTH = 8;
    localparam int HIER_DEPTH_W   = $clog2(HIER_MAX_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } hier_state_e;

    typedef struct packed {
        logic [HIER_DEPTH_W-1:0] depth;
        logic [HIER_ID_W-1:0]    id;
        logic                    last;
    } token_t;

    typedef struct packed {
        logic [HIER_ID_W-1:0]    parent;
        logic [HIER_ID_W-1:0]    child;
        logic [HIER_DEPTH_W-1:0] depth;
        logic                    root;
    } edge_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hier_stack.sv
// ---------------------------------------------------------------------------
// hier_stack
// Ancestor stack: DEPTH x ID_W register file holding the most recent node id
// seen at each depth. One combinational read port, one write port,
// synchronous clear.
// Ports:
//   clk    in   clock
//   clr    in   synchronous clear of every entry
//   we     in   write enable
//   waddr  in   write address (depth of the node being pushed)
//   wdata  in   node id to store
//   raddr  in   read address (depth of the wanted parent)
//   rdata  out  stored id at raddr
// ---------------------------------------------------------------------------
module hier_stack #(
    parameter int ID_W  = 8,
    parameter int DEPTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [ID_W-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [ID_W-1:0] rdata
);

    logic [ID_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/hier_stream_decoder.sv
// ---------------------------------------------------------------------------
// hier_stream_decoder
// Consumes (depth, id) tokens in depth-first pre-order and emits one
// parent->child edge per legal token. A malformed tree (depth jump > 1,
// non-root first token, or depth >= MAX_DEPTH) raises a one-cycle error
// pulse and every token up to the tree's last token is discarded.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid holds its payload stable until that edge, and ready may
// depend combinationally on the opposite side's ready (in_ready follows
// out_ready through the single output register).
//
// Build option: define HIER_DEC_STATS_EN to build the node_count/max_depth
// statistics; otherwise both outputs are tied to 0.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         token handshake
//   in_depth/in_id/in_last    token payload
//   out_valid/out_ready       edge handshake
//   out_parent/out_child      edge ids (parent 0 for a root)
//   out_depth/out_root        child depth, child is a root
//   err_jump/err_ovf/done     one-cycle status pulses
//   node_count/max_depth      per-tree statistics
// ---------------------------------------------------------------------------
module hier_stream_decoder
    import hier_pkg::*;
#(
    parameter int ID_W      = HIER_ID_W,
    parameter int MAX_DEPTH = HIER_MAX_DEPTH,
    parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DEPTH_W-1:0] in_depth,
    input  logic [ID_W-1:0]    in_id,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ID_W-1:0]    out_parent,
    output logic [ID_W-1:0]    out_child,
    output logic [DEPTH_W-1:0] out_depth,
    output logic               out_root,
    output logic               err_jump,
    output logic               err_ovf,
    output logic               done,
    output logic [15:0]        node_count,
    output logic [DEPTH_W-1:0] max_depth
);

    localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    // One extra bit so prev+1 and the MAX_DEPTH bound never wrap.
    localparam logic [DEPTH_W:0] MAXD_X = (DEPTH_W+1)'(MAX_DEPTH);
    localparam logic [DEPTH_W:0] ONE_X  = (DEPTH_W+1)'(1);

    hier_state_e        state_q, state_d;
    logic [DEPTH_W-1:0] prev_q, prev_d;
    logic               out_valid_q, out_valid_d;
    logic [ID_W-1:0]    out_parent_q, out_parent_d;
    logic [ID_W-1:0]    out_child_q, out_child_d;
    logic [DEPTH_W-1:0] out_depth_q, out_depth_d;
    logic               out_root_q, out_root_d;
    logic               err_jump_q, err_jump_d;
    logic               err_ovf_q, err_ovf_d;
    logic               done_q, done_d;

    logic               accept, is_ovf, is_jump, legal;
    logic [DEPTH_W:0]   depth_x, prev_x;
    logic [ID_W-1:0]    stk_rdata;

    assign in_ready = (state_q == ST_DRAIN) || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign depth_x  = {1'b0, in_depth};
    assign prev_x   = {1'b0, prev_q};

    // Overflow outranks a jump; the first token of a tree only has to be a root.
    always_comb begin
        is_ovf  = 1'b0;
        is_jump = 1'b0;
        if (state_q == ST_START) begin
            is_jump = (in_depth != '0);
        end else if (state_q == ST_RUN) begin
            if (depth_x >= MAXD_X) begin
                is_ovf = 1'b1;
            end else if (depth_x > prev_x + ONE_X) begin
                is_jump = 1'b1;
            end
        end
    end

    assign legal = (state_q != ST_DRAIN) && !is_ovf && !is_jump;

    // Parent is read at depth-1 in the same cycle the child is written at depth.
    hier_stack #(
        .ID_W  (ID_W),
        .DEPTH (MAX_DEPTH),
        .AW    (AW)
    ) u_stack (
        .clk   (clk),
        .clr   (rst),
        .we    (accept && legal),
        .waddr (in_depth[AW-1:0]),
        .wdata (in_id),
        .raddr (in_depth[AW-1:0] - AW'(1)),
        .rdata (stk_rdata)
    );

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_parent_d = out_parent_q;
        out_child_d  = out_child_q;
        out_depth_d  = out_depth_q;
        out_root_d   = out_root_q;
        err_jump_d   = 1'b0;
        err_ovf_d    = 1'b0;
        done_d       = 1'b0;
        if (accept) begin
            err_jump_d = is_jump;
            err_ovf_d  = is_ovf;
            done_d     = in_last;
            if (legal) begin
                out_valid_d  = 1'b1;
                out_root_d   = (in_depth == '0);
                out_parent_d = (in_depth == '0) ? '0 : stk_rdata;
                out_child_d  = in_id;
                out_depth_d  = in_depth;
                prev_d       = in_depth;
                state_d      = ST_RUN;
            end else begin
                state_d = ST_DRAIN;
            end
            if (in_last) begin
                state_d = ST_START;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_START;
            prev_q       <= '0;
            out_valid_q  <= 1'b0;
            out_parent_q <= '0;
            out_child_q  <= '0;
            out_depth_q  <= '0;
            out_root_q   <= 1'b0;
            err_jump_q   <= 1'b0;
            err_ovf_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            out_valid_q  <= out_valid_d;
            out_parent_q <= out_parent_d;
            out_child_q  <= out_child_d;
            out_depth_q  <= out_depth_d;
            out_root_q   <= out_root_d;
            err_jump_q   <= err_jump_d;
            err_ovf_q    <= err_ovf_d;
            done_q       <= done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_parent = out_parent_q;
    assign out_child  = out_child_q;
    assign out_depth  = out_depth_q;
    assign out_root   = out_root_q;
    assign err_jump   = err_jump_q;
    assign err_ovf    = err_ovf_q;
    assign done       = done_q;

`ifdef HIER_DEC_STATS_EN
    logic [15:0]        cnt_q, cnt_d;
    logic [DEPTH_W-1:0] maxd_q, maxd_d;

    // Dropped tokens count too; the first token of a tree restarts both stats.
    always_comb begin
        cnt_d  = cnt_q;
        maxd_d = maxd_q;
        if (accept) begin
            if (state_q == ST_START) begin
                cnt_d  = 16'd1;
                maxd_d = in_depth;
            end else begin
                cnt_d  = sat_inc16(cnt_q);
                maxd_d = (in_depth > maxd_q) ? in_depth : maxd_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            maxd_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            maxd_q <= maxd_d;
        end
    end

    assign node_count = cnt_q;
    assign max_depth  = maxd_q;
`else
    assign node_count = '0;
    assign max_depth  = '0;
`endif

endmodule

// File: tb/tb_hier_stream_decoder.sv
`timescale 1ns/1ps
module tb_hier_stream_decoder;

    localparam int ID_W      = 8;
    localparam int MAX_DEPTH = 8;
    localparam int DEPTH_W   = 4;
    localparam int EW        = 1 + DEPTH_W + 2 * ID_W;

    // ---------------- clock / reset / DUT ----------------
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [DEPTH_W-1:0] in_depth = '0;
    logic [ID_W-1:0]    in_id = '0;
    logic               in_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [ID_W-1:0]    out_parent, out_child;
    logic [DEPTH_W-1:0] out_depth;
    logic               out_root, err_jump, err_ovf, done;
    logic [15:0]        node_count;
    logic [DEPTH_W-1:0] max_depth;

    always #5 clk = ~clk;

    hier_stream_decoder #(.ID_W(ID_W), .MAX_DEPTH(MAX_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_depth(in_depth), .in_id(in_id), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_parent(out_parent), .out_child(out_child),
        .out_depth(out_depth), .out_root(out_root),
        .err_jump(err_jump), .err_ovf(err_ovf), .done(done),
        .node_count(node_count), .max_depth(max_depth)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];   // edges the DUT still owes, oldest first
    logic [EW-1:0] mlog[$];    // every edge the model ever produced
    int  hist_d[$];
    int  hist_id[$];
    bit  in_tree, dropping;
    bit  e_jump, e_ovf, e_done;
    int  e_cnt, e_max;
    int  n_pass, n_total;
    int  jump_seen, done_seen, ovf_done_seen;
    int  ready_mode;

    function automatic logic [EW-1:0] make_edge(input int parent, input int child,
                                                input int depth, input bit root);
        return {root, DEPTH_W'(depth), ID_W'(parent), ID_W'(child)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act !== expv) $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        else n_pass++;
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got timeout expected handshake at %0t", name, $time);
    endtask

    task automatic model_reset();
        exp_q.delete();
        in_tree = 0; dropping = 0;
        e_jump = 0; e_ovf = 0; e_done = 0;
        e_cnt = 0; e_max = 0;
    endtask

    // Parent = most recent legal node of this tree one level shallower.
    task automatic model_token(input int d, input int id, input bit last);
        int  parent;
        bit  found;
        if (!in_tree) begin
            hist_d.delete(); hist_id.delete();
            e_cnt = 0; e_max = 0;
        end
        if (e_cnt < 65535) e_cnt++;
        if (d > e_max) e_max = d;
        if (!dropping) begin
            if (hist_d.size() == 0 && d != 0) begin
                e_jump = 1; dropping = 1;
            end else if (hist_d.size() != 0 && d >= MAX_DEPTH) begin
                e_ovf = 1; dropping = 1;
            end else if (hist_d.size() != 0 && d > hist_d[hist_d.size()-1] + 1) begin
                e_jump = 1; dropping = 1;
            end else begin
                parent = 0; found = 0;
                for (int k = hist_d.size() - 1; k >= 0; k--) begin
                    if (!found && d != 0 && hist_d[k] == d - 1) begin
                        parent = hist_id[k]; found = 1;
                    end
                end
                exp_q.push_back(make_edge(parent, id, d, d == 0));
                mlog.push_back(make_edge(parent, id, d, d == 0));
                hist_d.push_back(d); hist_id.push_back(id);
            end
        end
        in_tree = 1;
        if (last) begin
            e_done = 1; in_tree = 0; dropping = 0;
        end
    endtask

    // ---------------- compare process (every negedge) ----------------
    initial begin
        bit acc;
        model_reset();
        forever begin
            @(negedge clk);
            chk("in_ready", in_ready, dropping || exp_q.size() == 0 || out_ready);
            chk("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0)
                chk("out_edge", {out_root, out_depth, out_parent, out_child}, exp_q[0]);
            chk("err_jump", err_jump, e_jump);
            chk("err_ovf", err_ovf, e_ovf);
            chk("done", done, e_done);
`ifdef HIER_DEC_STATS_EN
            chk("node_count", node_count, e_cnt);
            chk("max_depth", max_depth, e_max);
`else
            chk("node_count", node_count, 0);
            chk("max_depth", max_depth, 0);
`endif
            if (err_jump) jump_seen++;
            if (done) done_seen++;
            if (err_ovf && done) ovf_done_seen++;
            if (rst) begin
                model_reset();
            end else begin
                acc = in_valid && (dropping || exp_q.size() == 0 || out_ready);
                e_jump = 0; e_ovf = 0; e_done = 0;
                if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
                if (acc) model_token(int'(in_depth), int'(in_id), in_last);
            end
        end
    end

    // ---------------- drivers ----------------
    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input int d, input int id, input bit last);
        bit took;
        int n;
        in_valid = 1'b1; in_depth = DEPTH_W'(d); in_id = ID_W'(id); in_last = last;
        took = 0; n = 0;
        while (!took && n < 300) begin
            @(negedge clk); took = in_ready; n++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (!took) fail_now("accept_timeout");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_tree) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 300) fail_now("idle_timeout");
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [EW-1:0] t1_exp[8];
        logic [EW-1:0] t2_exp[4];
        int base, js, ds, od, d, prev, len, r;

        t1_exp[0] = make_edge(0, 10, 0, 1);  t1_exp[1] = make_edge(10, 11, 1, 0);
        t1_exp[2] = make_edge(11, 13, 2, 0); t1_exp[3] = make_edge(13, 14, 3, 0);
        t1_exp[4] = make_edge(11, 12, 2, 0); t1_exp[5] = make_edge(12, 13, 3, 0);
        t1_exp[6] = make_edge(10, 12, 1, 0); t1_exp[7] = make_edge(10, 20, 1, 0);
        t2_exp[0] = make_edge(0, 1, 0, 1);   t2_exp[1] = make_edge(1, 2, 1, 0);
        t2_exp[2] = make_edge(0, 5, 0, 1);   t2_exp[3] = make_edge(5, 6, 1, 0);

        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_fields", {out_root, out_depth, out_parent, out_child}, 0);
        chk("rst_pulses", {err_jump, err_ovf, done}, 0);
        chk("rst_stats", {node_count, max_depth}, 0);
        @(posedge clk); #1;

        // Tree 1: nested tree under continuous ready
        base = mlog.size(); ds = done_seen;
        send(0, 10, 0); send(1, 11, 0); send(2, 13, 0); send(3, 14, 0);
        send(2, 12, 0); send(3, 13, 0); send(1, 12, 0); send(1, 20, 1);
        wait_idle();
        for (int i = 0; i < 8; i++) chk("t1_edge", mlog[base + i], t1_exp[i]);
        chk("t1_done_once", done_seen - ds, 1);
`ifdef HIER_DEC_STATS_EN
        chk("t1_node_count", node_count, 8);
        chk("t1_max_depth", max_depth, 3);
`endif

        // Tree 2: two roots, random back-pressure
        ready_mode = 1;
        base = mlog.size();
        send(0, 1, 0); send(1, 2, 0); send(0, 5, 0); send(1, 6, 1);
        wait_idle();
        for (int i = 0; i < 4; i++) chk("t2_edge", mlog[base + i], t2_exp[i]);

        // Tree 3: depth jump, then a clean tree
        ready_mode = 0;
        base = mlog.size(); js = jump_seen; ds = done_seen;
        send(0, 1, 0); send(2, 2, 0); send(1, 3, 0); send(1, 4, 1);
        wait_idle();
        chk("t3_jump_once", jump_seen - js, 1);
        chk("t3_edges", mlog.size() - base, 1);
        chk("t3_done_once", done_seen - ds, 1);
        base = mlog.size();
        send(0, 9, 0); send(1, 8, 1);
        wait_idle();
        chk("t3_next_edge", mlog[base + 1], make_edge(9, 8, 1, 0));

        // Tree 4: overflow on the last token
        ready_mode = 1;
        base = mlog.size(); od = ovf_done_seen;
        for (int i = 0; i < 8; i++) send(i, i + 1, 0);
        send(8, 9, 1);
        wait_idle();
        chk("t4_edges", mlog.size() - base, 8);
        chk("t4_ovf_with_done", ovf_done_seen - od, 1);

        // Back-pressure hold: one edge pending, next token waiting
        ready_mode = 2; out_ready = 1'b0;
        send(0, 30, 0);
        in_valid = 1'b1; in_depth = 4'd1; in_id = 8'd31; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_child", out_child, 30);
            @(posedge clk); #1;
        end
        ready_mode = 0; out_ready = 1'b1;
        send(1, 31, 0); send(1, 32, 1);
        wait_idle();

        // Reset mid-tree with an edge pending
        ready_mode = 2; out_ready = 1'b0;
        send(0, 40, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_child", out_child, 0);
        chk("mid_rst_stats", {node_count, max_depth}, 0);
        @(posedge clk); #1;
        ready_mode = 0; out_ready = 1'b1;
        base = mlog.size();
        send(0, 7, 1);
        wait_idle();
        chk("after_rst_edge", mlog[base], make_edge(0, 7, 0, 1));

        // Random trees with occasional errors and gaps
        ready_mode = 1;
        for (int t = 0; t < 40; t++) begin
            len = $urandom_range(1, 12); prev = 0;
            for (int i = 0; i < len; i++) begin
                if (i == 0) begin
                    d = ($urandom_range(0, 9) == 0) ? 1 : 0;
                end else begin
                    r = $urandom_range(0, 24);
                    if (r == 0) d = (prev + 2 > 15) ? 15 : prev + 2;
                    else if (r == 1) d = $urandom_range(8, 15);
                    else d = $urandom_range(0, (prev < 7) ? prev + 1 : 7);
                end
                send(d, $urandom_range(1, 255), i == len - 1);
                prev = d;
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            end
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
